hash_target_check: RTL

HASH_TARGET_CHECK -- requirements
Module: hash_target_check

---
 rtl/htc_pkg.sv | 19 +
 rtl/fifo_in_out.sv | 57 +++++
 rtl/hash_target_check.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/htc_pkg.sv
// Shared widths, word-state encoding and compare helper for the hash target checker.
package htc_pkg;

    localparam int unsigned HASH_W         = 256;
    localparam int unsigned WORD_W         = 64;
    localparam int unsigned WORDS_PER_HASH = 4;
    localparam int unsigned TGT_WORD_W     = 32;
    localparam int unsigned TGT_WORDS      = 8;

    typedef enum logic [1:0] {W0, W1, W2, W3} word_state_t;

    // One step of a least-significant-word-first "hash <= target" evaluation.
    function automatic logic word_le(input logic [WORD_W-1:0] h,
                                     input logic [WORD_W-1:0] t,
                                     input logic              le_prev);
        return (h < t) | ((h == t) & le_prev);
    endfunction

endpackage

// File: rtl/fifo_in_out.sv
// First-word-fall-through FIFO with occupancy count; a pop frees space for a same-cycle push.
module fifo_in_out #(
    parameter int unsigned DINWIDTH  = 32,
    parameter int unsigned DOUTWIDTH = 32,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DINWIDTH-1:0]      din,
    input  logic                     we,
    input  logic                     re,
    output logic [DOUTWIDTH-1:0]     dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DINWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         count_q;
    logic                do_rd;
    logic                do_wr;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        do_rd = re & ~empty;
        do_wr = we & (~full | do_rd);
        count = count_q;
        dout  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/hash_target_check.sv
// Compares each 256-bit heavy-hash against the loaded target and queues winning nonces.
// Statistics counters are built only when HTC_STATS_EN is defined.
module hash_target_check
    import htc_pkg::*;
#(
    parameter int unsigned RES_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     hh_data,
    input  logic                  hh_we,
    output logic                  hh_out_re,
    input  logic [31:0]           nonce_in,
    output logic                  nonce_re,
    input  logic                  target_we,
    input  logic [TGT_WORD_W-1:0] target_din,
    output logic                  target_valid,
    input  logic                  res_re,
    output logic [31:0]           res_nonce,
    output logic                  res_empty,
    output logic                  res_full,
    output logic [31:0]           hash_cnt,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           drop_cnt
);

    localparam int unsigned CW = $clog2(RES_DEPTH) + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(RES_DEPTH - 3);

    word_state_t                             state_q;
    logic                                    le_q;
    logic                                    hit_q;
    logic [31:0]                             nonce_q;
    logic [HASH_W-1:0]                       shadow_q;
    logic [HASH_W-1:0]                       tgt_active_q;
    logic [TGT_WORDS-1:0][TGT_WORD_W-1:0]    tgt_stage_q;
    logic [2:0]                              wr_cnt_q;
    logic                                    tgt_valid_q;

    logic [WORDS_PER_HASH-1:0][WORD_W-1:0]   cmp_words;
    logic                                    le_prev;
    logic                                    le_next;
    logic                                    w3_acc;
    logic [CW-1:0]                           res_count;

    // The W0 word compares against the live target, which is the same value the shadow captures.
    always_comb begin
        cmp_words = (state_q == W0) ? tgt_active_q : shadow_q;
        le_prev   = (state_q == W0) ? 1'b1 : le_q;
        le_next   = word_le(hh_data, cmp_words[state_q], le_prev);
        w3_acc    = hh_we & (state_q == W3) & ~rst;
    end

    assign nonce_re     = w3_acc;
    assign target_valid = tgt_valid_q;
    assign hh_out_re    = (res_count <= READY_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= W0;
            le_q         <= 1'b1;
            hit_q        <= 1'b0;
            nonce_q      <= '0;
            shadow_q     <= '0;
            tgt_active_q <= '0;
            tgt_stage_q  <= '0;
            wr_cnt_q     <= '0;
            tgt_valid_q  <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (state_q == W0) shadow_q <= tgt_active_q;
            if (hh_we) begin
                le_q <= le_next;
                case (state_q)
                    W0: state_q <= W1;
                    W1: state_q <= W2;
                    W2: state_q <= W3;
                    W3: begin
                        state_q <= W0;
                        le_q    <= 1'b1;
                        nonce_q <= nonce_in;
                        hit_q   <= le_next & tgt_valid_q;
                    end
                    default: state_q <= W0;
                endcase
            end
            if (target_we) begin
                tgt_stage_q[wr_cnt_q] <= target_din;
                wr_cnt_q              <= wr_cnt_q + 3'd1;
                if (wr_cnt_q == 3'd7) begin
                    tgt_active_q <= {target_din, tgt_stage_q[6:0]};
                    tgt_valid_q  <= 1'b1;
                end
            end
        end
    end

    fifo_in_out #(
        .DINWIDTH  (32),
        .DOUTWIDTH (32),
        .DEPTH     (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (nonce_q),
        .we    (hit_q),
        .re    (res_re),
        .dout  (res_nonce),
        .empty (res_empty),
        .full  (res_full),
        .count (res_count)
    );

`ifdef HTC_STATS_EN
    logic [31:0] hash_cnt_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] drop_cnt_q;

    // A same-cycle pop makes room, so only a push into a full FIFO without res_re is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_cnt_q <= '0;
            hit_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (w3_acc) hash_cnt_q <= hash_cnt_q + 32'd1;
            if (w3_acc & le_next & tgt_valid_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (hit_q & res_full & ~res_re) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign hash_cnt = hash_cnt_q;
    assign hit_cnt  = hit_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign hash_cnt = '0;
    assign hit_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule
